// File: rtl/lcd_12864_pkg.sv
// ---------------------------------------------------------------------------
// lcd_12864_pkg
// Shared types and constants for the ST7920 12864 LCD read-side engine.
//   rd_state_t     : top-level read FSM states
//   pulse_phase_t  : phases of one E strobe inside lcd_12864_rd_pulse
//   RS_CMD/RS_DATA : register-select encodings (BF/AC read vs RAM data read)
//   T_*_DEF        : default timing in clk cycles at 50 MHz
//   BF_BIT         : busy-flag bit position in a BF/AC read
// ---------------------------------------------------------------------------
package lcd_12864_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_CHECK,
        ST_MAIN,
        ST_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_LOW
    } pulse_phase_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam int T_AS_DEF     = 4;    // >= 80 ns RS/RW setup
    localparam int T_PW_DEF     = 25;   // 500 ns E high, 500 ns E low
    localparam int POLL_MAX_DEF = 255;

    localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_12864_rd_pulse.sv
// ---------------------------------------------------------------------------
// lcd_12864_rd_pulse
// Generates one read strobe on the LCD bus: SETUP (T_AS cycles, E low),
// E_HIGH (T_PW cycles), E_LOW (T_PW cycles). The data bus is captured on the
// last E_HIGH cycle. A go pulse restarts the sequence from SETUP at any time,
// including in the final E_LOW cycle, so back-to-back strobes have no gap.
// Ports:
//   clk_50M, rst   : clock, synchronous active-high reset
//   go             : start a strobe (single cycle)
//   rs             : register select for this strobe, latched at go
//   lcd_data_in    : LCD data bus input
//   lcd_e          : registered E strobe
//   lcd_rs         : latched RS, stable for the whole strobe
//   sample         : byte captured at the end of E_HIGH
//   done           : high in the last E_LOW cycle
// T_AS and T_PW must both be at least 1.
// ---------------------------------------------------------------------------
module lcd_12864_rd_pulse
    import lcd_12864_pkg::*;
#(
    parameter int T_AS = T_AS_DEF,
    parameter int T_PW = T_PW_DEF
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] sample,
    output logic       done
);

    localparam int T_MAX = (T_AS > T_PW) ? T_AS : T_PW;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] AS_LAST = CW'(T_AS - 1);
    localparam logic [CW-1:0] PW_LAST = CW'(T_PW - 1);

    pulse_phase_t  phase_reg;
    logic [CW-1:0] timer_reg;
    logic          e_reg;
    logic          rs_reg;
    logic [7:0]    sample_reg;

    assign lcd_e  = e_reg;
    assign lcd_rs = rs_reg;
    assign sample = sample_reg;
    assign done   = (phase_reg == PH_LOW) && (timer_reg == PW_LAST);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            phase_reg  <= PH_IDLE;
            timer_reg  <= '0;
            e_reg      <= 1'b0;
            rs_reg     <= 1'b0;
            sample_reg <= '0;
        end else if (go) begin
            phase_reg <= PH_SETUP;
            timer_reg <= '0;
            e_reg     <= 1'b0;
            rs_reg    <= rs;
        end else begin
            case (phase_reg)
                PH_SETUP: begin
                    if (timer_reg == AS_LAST) begin
                        phase_reg <= PH_HIGH;
                        timer_reg <= '0;
                        e_reg     <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (timer_reg == PW_LAST) begin
                        // ST7920 drives valid data while E is high; latch it
                        // just before E falls.
                        phase_reg  <= PH_LOW;
                        timer_reg  <= '0;
                        e_reg      <= 1'b0;
                        sample_reg <= lcd_data_in;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                PH_LOW: begin
                    if (timer_reg == PW_LAST) begin
                        phase_reg <= PH_IDLE;
                        timer_reg <= '0;
                        rs_reg    <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    timer_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_12864_reader.sv
// ---------------------------------------------------------------------------
// lcd_12864_reader
// Read-side engine for the ST7920 12864 LCD 8-bit parallel bus. Performs
// BF/AC reads (RS=0) and DDRAM/GDRAM data reads (RS=1), optionally polling
// the busy flag before the main read. The top level muxes lcd_rs/lcd_rw/lcd_e
// with the write path using bus_own.
// Ports:
//   clk_50M, rst        : 50 MHz clock, synchronous active-high reset
//   rd_req/rd_ready     : request handshake (accept = rd_req & rd_ready)
//   rd_rs, rd_poll      : read type and poll enable, captured at accept
//   rd_valid            : one-cycle result strobe
//   rd_data, rd_busy    : result byte and busy bit (BF/AC reads only)
//   rd_timeout          : busy flag never cleared within POLL_MAX polls
//   bus_own             : engine owns the LCD bus (accept .. rd_valid)
//   lcd_rs/lcd_rw/lcd_e : LCD control lines
//   lcd_data_in         : LCD data bus input side
// Build option: define LCD_DUMMY_READ_EN to issue a discarded dummy strobe
// before every RAM data read.
// ---------------------------------------------------------------------------
module lcd_12864_reader
    import lcd_12864_pkg::*;
#(
    parameter int T_AS     = T_AS_DEF,
    parameter int T_PW     = T_PW_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_busy,
    output logic       rd_timeout,
    output logic       bus_own,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_data_in
);

`ifdef LCD_DUMMY_READ_EN
    localparam bit DUMMY_EN = 1'b1;
`else
    localparam bit DUMMY_EN = 1'b0;
`endif

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    rd_state_t  state_reg;
    logic [7:0] poll_cnt_reg;
    logic       rs_req_reg;
    logic       dummy_reg;
    logic       rd_ready_reg;
    logic       rd_valid_reg;
    logic [7:0] rd_data_reg;
    logic       rd_busy_reg;
    logic       rd_timeout_reg;
    logic       bus_own_reg;

    logic       go;
    logic       go_rs;
    logic       pulse_done;
    logic [7:0] sample;
    logic       bf;
    logic       poll_more;

    assign bf        = sample[BF_BIT];
    assign poll_more = (poll_cnt_reg < POLL_LIMIT);

    assign rd_ready   = rd_ready_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_data_reg;
    assign rd_busy    = rd_busy_reg;
    assign rd_timeout = rd_timeout_reg;
    assign bus_own    = bus_own_reg;
    assign lcd_rw     = bus_own_reg;

    // Strobe launch is decoded from the current state so a new pulse starts on
    // the same edge as the state change, keeping strobes back-to-back.
    always_comb begin
        go    = 1'b0;
        go_rs = RS_CMD;
        case (state_reg)
            ST_IDLE: begin
                if (rd_req) begin
                    go    = 1'b1;
                    go_rs = rd_poll ? RS_CMD : rd_rs;
                end
            end
            ST_CHECK: begin
                if (!bf) begin
                    go    = 1'b1;
                    go_rs = rs_req_reg;
                end else if (poll_more) begin
                    go    = 1'b1;
                    go_rs = RS_CMD;
                end
            end
            ST_MAIN: begin
                if (pulse_done && dummy_reg) begin
                    go    = 1'b1;
                    go_rs = rs_req_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            poll_cnt_reg   <= '0;
            rs_req_reg     <= RS_CMD;
            dummy_reg      <= 1'b0;
            rd_ready_reg   <= 1'b1;
            rd_valid_reg   <= 1'b0;
            rd_data_reg    <= '0;
            rd_busy_reg    <= 1'b0;
            rd_timeout_reg <= 1'b0;
            bus_own_reg    <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rd_req) begin
                        state_reg      <= rd_poll ? ST_POLL : ST_MAIN;
                        poll_cnt_reg   <= '0;
                        rs_req_reg     <= rd_rs;
                        dummy_reg      <= DUMMY_EN && (rd_rs == RS_DATA);
                        rd_ready_reg   <= 1'b0;
                        rd_timeout_reg <= 1'b0;
                        bus_own_reg    <= 1'b1;
                    end
                end
                ST_POLL: begin
                    if (pulse_done) begin
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!bf) begin
                        state_reg <= ST_MAIN;
                    end else if (poll_more) begin
                        poll_cnt_reg <= poll_cnt_reg + 8'd1;
                        state_reg    <= ST_POLL;
                    end else begin
                        // Give up: report the last poll sample as the result.
                        state_reg      <= ST_DONE;
                        rd_valid_reg   <= 1'b1;
                        rd_timeout_reg <= 1'b1;
                        rd_data_reg    <= sample;
                        rd_busy_reg    <= (rs_req_reg == RS_CMD) && bf;
                    end
                end
                ST_MAIN: begin
                    if (pulse_done) begin
                        if (dummy_reg) begin
                            // First RAM strobe after an address set is a dummy.
                            dummy_reg <= 1'b0;
                        end else begin
                            state_reg    <= ST_DONE;
                            rd_valid_reg <= 1'b1;
                            rd_data_reg  <= sample;
                            rd_busy_reg  <= (rs_req_reg == RS_CMD) && bf;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    rd_ready_reg <= 1'b1;
                    bus_own_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    lcd_12864_rd_pulse #(
        .T_AS (T_AS),
        .T_PW (T_PW)
    ) u_pulse (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .go          (go),
        .rs          (go_rs),
        .lcd_data_in (lcd_data_in),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .sample      (sample),
        .done        (pulse_done)
    );

endmodule

// File: tb/tb_lcd_12864_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_12864_reader
// Directed bench for lcd_12864_reader with a small ST7920 read model.
// The model answers BF/AC strobes with 0x80 for the first busy_polls strobes
// and cmd_byte afterwards; RAM strobes return ram[0], then ram[1].
// Build option LCD_DUMMY_READ_EN changes the expected RAM-read results.
// ---------------------------------------------------------------------------
module tb_lcd_12864_reader;

`ifdef LCD_DUMMY_READ_EN
    localparam bit DUMMY = 1'b1;
`else
    localparam bit DUMMY = 1'b0;
`endif

    logic       clk_50M = 1'b0;
    logic       rst;
    logic       rd_req;
    logic       rd_rs;
    logic       rd_poll;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_busy;
    logic       rd_timeout;
    logic       bus_own;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_in;

    always #10 clk_50M = ~clk_50M;

    lcd_12864_reader #(
        .T_AS     (4),
        .T_PW     (25),
        .POLL_MAX (4)
    ) dut (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_rs       (rd_rs),
        .rd_poll     (rd_poll),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .rd_timeout  (rd_timeout),
        .bus_own     (bus_own),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data_in (lcd_data_in)
    );

    int checks = 0;
    int errors = 0;

    // LCD model state
    int         busy_polls;
    logic [7:0] cmd_byte;
    logic [7:0] ram [0:1];
    int         poll_idx;
    int         main_idx;
    logic       e_prev = 1'b0;

    // per-transaction monitors
    int cyc;
    int e_high;
    int n_poll;
    int n_main;
    bit rs_seen;
    bit saw_valid;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; e_high = 0; n_poll = 0; n_main = 0;
        rs_seen = 0; saw_valid = 0; poll_idx = 0; main_idx = 0;
    endtask

    // Advance one cycle, observe at the falling clock edge and update the model.
    task automatic step();
        @(negedge clk_50M);
        cyc++;
        if (lcd_e) e_high++;
        if (lcd_e && !e_prev) begin
            if (lcd_rs) n_main++; else n_poll++;
        end
        if (!lcd_e && e_prev) begin
            if (lcd_rs) main_idx++; else poll_idx++;
        end
        if (lcd_rs) rs_seen = 1;
        e_prev = lcd_e;
        lcd_data_in = lcd_rs ? ram[(main_idx > 1) ? 1 : main_idx]
                             : ((poll_idx < busy_polls) ? 8'h80 : cmd_byte);
    endtask

    // Issue one request from a negedge and wait (bounded) for rd_valid.
    task automatic do_read(input logic rs, input logic poll, input int budget);
        chk("ready_before_req", int'(rd_ready), 1);
        clear_mon();
        rd_rs = rs; rd_poll = poll; rd_req = 1'b1;
        while (!saw_valid && cyc < budget) begin
            step();
            if (cyc == 1) rd_req = 1'b0;
            if (rd_valid) saw_valid = 1;
        end
        chk("valid_seen", int'(saw_valid), 1);
    endtask

    int v_at [0:2];
    int nv;
    int rw_low;
    int rw_bad;
    int valid_after_rst;

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_rs = 1'b0; rd_poll = 1'b0;
        lcd_data_in = 8'h00; busy_polls = 0; cmd_byte = 8'h00;
        ram[0] = 8'h00; ram[1] = 8'h00;
        repeat (3) @(negedge clk_50M);

        // Reset state
        chk("rst_ready", int'(rd_ready), 1);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_bus_own", int'(bus_own), 0);
        chk("rst_lcd_e", int'(lcd_e), 0);
        chk("rst_lcd_rw", int'(lcd_rw), 0);
        chk("rst_timeout", int'(rd_timeout), 0);
        rst = 1'b0;
        step();

        // 1: BF/AC read, no poll, model returns 0x1A
        cmd_byte = 8'h1A; busy_polls = 0;
        do_read(1'b0, 1'b0, 200);
        chk("t1_latency", cyc, 55);
        chk("t1_data", int'(rd_data), 8'h1A);
        chk("t1_busy", int'(rd_busy), 0);
        chk("t1_e_high", e_high, 25);
        chk("t1_rw", int'(lcd_rw), 1);
        chk("t1_bus_own", int'(bus_own), 1);
        step();
        chk("t1_valid_pulse", int'(rd_valid), 0);
        chk("t1_ready_back", int'(rd_ready), 1);
        $display("T1 bf/ac read: data=0x%0h lat=%0d e_high=%0d", rd_data, cyc - 1, e_high);

        // 2: RAM read with poll, BF=1 for 3 polls, then clear
        busy_polls = 3; cmd_byte = 8'h00; ram[0] = 8'hC7; ram[1] = 8'hC7;
        do_read(1'b1, 1'b1, 600);
        chk("t2_polls", n_poll, 4);
        chk("t2_mains", n_main, DUMMY ? 2 : 1);
        chk("t2_data", int'(rd_data), 8'hC7);
        chk("t2_timeout", int'(rd_timeout), 0);
        chk("t2_busy", int'(rd_busy), 0);
        step();
        $display("T2 polled ram read: polls=%0d mains=%0d data=0x%0h", n_poll, n_main, rd_data);

        // 3: BF stuck busy, POLL_MAX=4 -> timeout after 5 polls, no MAIN
        busy_polls = 1000; ram[0] = 8'h33; ram[1] = 8'h33;
        do_read(1'b1, 1'b1, 600);
        chk("t3_polls", n_poll, 5);
        chk("t3_mains", n_main, 0);
        chk("t3_rs_seen", int'(rs_seen), 0);
        chk("t3_timeout", int'(rd_timeout), 1);
        chk("t3_data", int'(rd_data), 8'h80);
        step();
        $display("T3 poll timeout: polls=%0d timeout=%0b data=0x%0h", n_poll, rd_timeout, rd_data);

        // 4: reset during E_HIGH of MAIN
        busy_polls = 0; ram[0] = 8'h5A;
        clear_mon();
        rd_rs = 1'b1; rd_poll = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        repeat (9) step();
        chk("t4_in_e_high", int'(lcd_e), 1);
        rst = 1'b1;
        step();
        chk("t4_e_drop", int'(lcd_e), 0);
        chk("t4_bus_own", int'(bus_own), 0);
        chk("t4_ready", int'(rd_ready), 1);
        chk("t4_valid", int'(rd_valid), 0);
        rst = 1'b0;
        valid_after_rst = 0;
        repeat (70) begin
            step();
            if (rd_valid) valid_after_rst++;
        end
        chk("t4_no_valid", valid_after_rst, 0);
        $display("T4 reset mid-read: lcd_e=%0b ready=%0b spurious_valid=%0d", lcd_e, rd_ready, valid_after_rst);

        // 5: rd_req held high for three back-to-back requests
        cmd_byte = 8'h1A; busy_polls = 0;
        clear_mon();
        nv = 0; rw_low = 0; rw_bad = 0;
        rd_rs = 1'b0; rd_poll = 1'b0; rd_req = 1'b1;
        while (nv < 3 && cyc < 400) begin
            step();
            if (!lcd_rw) begin
                rw_low++;
                if (!rd_ready) rw_bad++;
            end
            if (rd_valid) begin
                v_at[nv] = cyc;
                nv++;
            end
        end
        rd_req = 1'b0;
        chk("t5_valids", nv, 3);
        if (nv == 3) begin
            chk("t5_gap1", v_at[1] - v_at[0], 56);
            chk("t5_gap2", v_at[2] - v_at[1], 56);
        end
        chk("t5_rw_low_cycles", rw_low, 2);
        chk("t5_rw_low_not_idle", rw_bad, 0);
        chk("t5_data", int'(rd_data), 8'h1A);
        step();
        step();
        chk("t5_idle_ready", int'(rd_ready), 1);
        $display("T5 back-to-back: valids=%0d rw_low=%0d", nv, rw_low);

        // 6: RAM read, model returns 0xFF then 0xEB
        ram[0] = 8'hFF; ram[1] = 8'hEB;
        do_read(1'b1, 1'b0, 300);
        chk("t6_latency", cyc, DUMMY ? 109 : 55);
        chk("t6_data", int'(rd_data), DUMMY ? 8'hEB : 8'hFF);
        chk("t6_mains", n_main, DUMMY ? 2 : 1);
        chk("t6_busy", int'(rd_busy), 0);
        step();
        $display("T6 ram read: data=0x%0h lat=%0d mains=%0d", rd_data, cyc - 1, n_main);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
